// File: rtl/hit_judge.sv
// Scoring stage for the piano-tile game: judges key pulses against the chart note
// of the current beat and keeps BCD score, combo, lives and the game state.
module hit_judge #(
  parameter int LIVES_INIT  = 3,
  parameter int BONUS_COMBO = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [6:0] beat_cnt_i,
  input  logic       note_valid_i,
  input  logic [1:0] note_lane_i,
  input  logic [3:0] key_pulse_i,
  output logic [2:0] state_o,
  output logic [11:0] score_o,
  output logic [6:0] combo_o,
  output logic [1:0] lives_o,
  output logic       hit_flash_o,
  output logic       miss_flash_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3,
    CLEAR = 3'd4
  } state_e;

  localparam logic [1:0] LIVES_I = LIVES_INIT[1:0];
  localparam logic [6:0] BONUS_C = BONUS_COMBO[6:0];
  localparam logic [6:0] BEAT_LAST = 7'd96;
  localparam logic [6:0] COMBO_MAX = 7'd127;

  state_e      state_q, state_d;
  logic [6:0]  beat_prev_q, beat_prev_d;
  logic        pending_q, pending_d;
  logic [11:0] score_q, score_d;
  logic [6:0]  combo_q, combo_d;
  logic [1:0]  lives_q, lives_d;
  logic        hit_flash_q, hit_flash_d;
  logic        miss_flash_q, miss_flash_d;

  logic       beat_edge;
  logic       wrap;
  logic       key_match;
  logic       judge_open;
  logic       hit;
  logic       wrong;
  logic       closure;
  logic [1:0] miss_cnt;
  logic [6:0] combo_base;

  // Three-digit BCD add of 1 or 2; anything beyond 999 pins at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] val, input logic [1:0] inc);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    d0 = val[3:0] + {2'b00, inc};
    d1 = val[7:4];
    d2 = val[11:8];
    if (d0 > 4'd9) begin
      d0 = d0 - 4'd10;
      d1 = d1 + 4'd1;
    end
    if (d1 > 4'd9) begin
      d1 = d1 - 4'd10;
      d2 = d2 + 4'd1;
    end
    if (d2 > 4'd9) begin
      return 12'h999;
    end
    return {d2, d1, d0};
  endfunction

  // On a beat edge presses are judged against the new note; otherwise against the open one.
  assign beat_edge  = (beat_cnt_i != beat_prev_q);
  assign wrap       = (beat_prev_q == BEAT_LAST) && (beat_cnt_i == 7'd0);
  assign key_match  = (key_pulse_i == (4'b0001 << note_lane_i));
  assign judge_open = beat_edge ? note_valid_i : pending_q;
  assign hit        = judge_open && key_match;
  assign wrong      = judge_open && (|key_pulse_i) && !key_match;
  assign closure    = beat_edge && pending_q;
  assign miss_cnt   = {1'b0, closure} + {1'b0, wrong};
  assign combo_base = closure ? 7'd0 : combo_q;

  always_comb begin
    state_d      = state_q;
    beat_prev_d  = beat_cnt_i;
    pending_d    = pending_q;
    score_d      = score_q;
    combo_d      = combo_q;
    lives_d      = lives_q;
    hit_flash_d  = 1'b0;
    miss_flash_d = 1'b0;

    if (start_i) begin
      state_d   = PLAY;
      score_d   = 12'h000;
      combo_d   = 7'd0;
      lives_d   = LIVES_I;
      pending_d = note_valid_i;
    end else begin
      case (state_q)
        PLAY: begin
          pending_d = judge_open && !(hit || wrong);
          if (miss_cnt != 2'd0) begin
            combo_d      = 7'd0;
            lives_d      = (lives_q > miss_cnt) ? (lives_q - miss_cnt) : 2'd0;
            miss_flash_d = 1'b1;
          end
          // A closure miss on the edge cycle resets the streak before a hit on the new note counts.
          if (hit) begin
            combo_d     = (combo_base == COMBO_MAX) ? COMBO_MAX : (combo_base + 7'd1);
            score_d     = bcd_add(score_q, (combo_base >= BONUS_C) ? 2'd2 : 2'd1);
            hit_flash_d = 1'b1;
          end
          if (lives_d == 2'd0) begin
            state_d = OVER;
          end else if (wrap) begin
            state_d = CLEAR;
          end else if (stop_i) begin
            state_d = PAUSE;
          end else begin
            state_d = PLAY;
          end
        end
        PAUSE: begin
          if (!stop_i) begin
            state_d = PLAY;
          end
        end
        IDLE, OVER, CLEAR: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_prev_q  <= 7'd0;
      pending_q    <= 1'b0;
      score_q      <= 12'h000;
      combo_q      <= 7'd0;
      lives_q      <= LIVES_I;
      hit_flash_q  <= 1'b0;
      miss_flash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_prev_q  <= beat_prev_d;
      pending_q    <= pending_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      lives_q      <= lives_d;
      hit_flash_q  <= hit_flash_d;
      miss_flash_q <= miss_flash_d;
    end
  end

  assign state_o      = state_q;
  assign score_o      = score_q;
  assign combo_o      = combo_q;
  assign lives_o      = lives_q;
  assign hit_flash_o  = hit_flash_q;
  assign miss_flash_o = miss_flash_q;

endmodule

// File: doc/hit_judge.md
# hit_judge

Scoring stage directly downstream of the beat counter in the piano-tile game. Each cycle it compares the player's one-shot key pulses against the chart note for the current beat (`beat_cnt` 0..96), judges hits, wrong-lane presses and missed notes, and maintains BCD score, combo and lives. A small game FSM drives the display, the LED and the counter's `stop`/`restart` control logic.

## Interface
- `LIVES_INIT`, 3: lives loaded at game start (1..3).
- `BONUS_COMBO`, 10: combo value at or above which a hit scores 2 instead of 1.
- `clk` in 1: system clock; all inputs are synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; starts or restarts a game.
- `stop` in 1: level; pause request.
- `beat_cnt` in 7: beat index from the beat counter, 0..96.
- `note_valid` in 1: chart ROM output; a note exists at `beat_cnt`. Combinational from `beat_cnt`.
- `note_lane` in 2: chart ROM output; lane of that note.
- `key_pulse` in 4: debounced one-cycle key pulses, one bit per lane.
- `state` out 3: IDLE=0, PLAY=1, PAUSE=2, OVER=3, CLEAR=4.
- `score` out 12: 3-digit BCD, saturates at 999.
- `combo` out 7: consecutive hits, binary, saturates at 127.
- `lives` out 2: remaining lives.
- `hit_flash` out 1: one-cycle pulse per hit.
- `miss_flash` out 1: one-cycle pulse per cycle with at least one miss event.

## Operation
- Registers: `beat_prev` (7b), `pending` (1b, current-beat note still open), plus all outputs.
- `beat_prev <= beat_cnt` every cycle in every state. A beat edge is `beat_cnt != beat_prev`. A wrap is `beat_prev==96 && beat_cnt==0`.
- IDLE: on `start`, go to PLAY. Clear score and combo, set lives=LIVES_INIT, set pending=note_valid.
- OVER/CLEAR: these states hold all outputs. On `start`, behave exactly as in IDLE.
- PLAY, evaluated each cycle. All events below are computed from the registered values at cycle start.
  - Closure miss: beat edge and `pending`=1.
  - Hit: `pending`, no beat edge, `key_pulse == 1<<note_lane`. Effects: clear pending, combo+1, score += (combo>=BONUS_COMBO ? 2 : 1).
  - Wrong-lane miss: `pending`, no beat edge, `key_pulse` nonzero and not exactly the correct bit. Effect: clear pending.
  - On a beat edge, key presses are judged against the new beat only. A press on the edge cycle counts as a hit if it exactly matches the new note, otherwise a wrong-lane miss. Pending is then set to new note_valid AND NOT (hit or wrong).
  - `key_pulse` with no pending note is ignored.
  - Each miss event clears combo and decrements lives by 1. At most 2 events per cycle; lives floor at 0.
  - Next state priority:
    - lives reach 0 → OVER.
    - else wrap → CLEAR (beat-96 closure is judged first).
    - else `stop` → PAUSE.
- PAUSE: no judging; key pulses are ignored and pending is held. If `stop`=0, return to PLAY. A beat edge during PAUSE updates beat_prev only.
- `start` in PLAY/PAUSE restarts the game exactly as from IDLE.
- BCD add: per-digit carry; any result >999 saturates to 999.

## Timing
- Reset values: state=IDLE, score=0, combo=0, lives=LIVES_INIT, hit_flash=0, miss_flash=0, pending=0, beat_prev=0.
- Reset has priority over `start` and over every other input.
- Latency: a key pulse or beat edge in cycle N updates score/combo/lives/state/flashes at the clock edge ending cycle N; the new values are visible in cycle N+1.
- Flashes are high for exactly one cycle per qualifying cycle.
- Back-to-back key pulses are judged independently every cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset with chart empty → state=0, score=0x000, combo=0, lives=3. Then `start` → state=1 next cycle.
- Note lane 2 at beat 5; pulse `key_pulse`=4'b0100 mid-beat → score 0x001, combo 1, hit_flash for 1 cycle. A second pulse in the same beat → no change.
- Note at beat 7 with no press, then beat advances to 8 → lives 3→2, combo→0, miss_flash 1 cycle. Wrong press `4'b0011` on lane-0 note → lives −1.
- Eleven consecutive hits starting from score 0 → after the 11th hit, score=0x012 (bonus applies once combo≥10). Preload score to 998 and hit with combo≥10 → score saturates at 0x999.
- Lives=1, note missed at the same cycle as a wrong press on the new note → lives=0, state=OVER. `start` → PLAY with lives=3 and score=0.
- Beat wrap 96→0 with lives>0 → state=CLEAR. `stop` held 3 cycles in PLAY with a key pulse → PAUSE, no score change, returns to PLAY on release.
